// File: rtl/permute_seq_ctrl.sv
// Control sequencer for a sliced permutation datapath. It walks SLICES slices per round for ROUNDS rounds.
// Optional build macro PERMUTE_RD_STALL_EN: LOAD waits for rd_valid from the state memory.
module permute_seq_ctrl #(
  parameter int SLICES = 64,
  parameter int ROUNDS = 24,
  localparam int SW = (SLICES > 1) ? $clog2(SLICES) : 1,
  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          rd_valid,
  output logic          rd_en,
  output logic          ld,
  output logic          sel,
  output logic          wr_en,
  output logic [SW-1:0] addr,
  output logic [RW-1:0] round,
  output logic          slice_ready,
  output logic          round_done,
  output logic          done,
  output logic [2:0]    state_dbg
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] INIT    = 3'd1;
  localparam logic [2:0] LOAD    = 3'd2;
  localparam logic [2:0] CALC    = 3'd3;
  localparam logic [2:0] STORE   = 3'd4;
  localparam logic [2:0] RND_END = 3'd5;

  localparam logic [SW-1:0] LAST_SLICE = SW'(SLICES - 1);
  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       load_go;

  // Read handshake: rd_en stays high for the whole LOAD state. The datapath
  // captures memory data (ld) only in a cycle where rd_valid is seen, and LOAD
  // ends on that same cycle.
`ifdef PERMUTE_RD_STALL_EN
  assign load_go = rd_valid;
`else
  logic unused_rd_valid;
  assign unused_rd_valid = rd_valid;
  assign load_go = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = INIT;
      INIT:    state_nxt = LOAD;
      LOAD:    if (load_go) state_nxt = CALC;
      CALC:    state_nxt = STORE;
      STORE:   state_nxt = (addr == LAST_SLICE) ? RND_END : LOAD;
      RND_END: state_nxt = (round == LAST_ROUND) ? IDLE : LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // addr/round change only when leaving STORE/RND_END, so each slice's triple sees stable indices.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      addr  <= '0;
      round <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        INIT: begin
          addr  <= '0;
          round <= '0;
        end
        STORE: begin
          if (addr == LAST_SLICE) addr <= '0;
          else                    addr <= addr + 1'b1;
        end
        RND_END: begin
          if (round != LAST_ROUND) round <= round + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_en       = 1'b0;
    ld          = 1'b0;
    sel         = 1'b0;
    wr_en       = 1'b0;
    slice_ready = 1'b0;
    round_done  = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE:    done = 1'b1;
      LOAD: begin
        rd_en = 1'b1;
        ld    = load_go;
      end
      CALC: begin
        ld  = 1'b1;
        sel = 1'b1;
      end
      STORE: begin
        wr_en       = 1'b1;
        slice_ready = 1'b1;
      end
      RND_END: round_done = 1'b1;
      default: ;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_permute_seq_ctrl.sv
// Self-checking bench for permute_seq_ctrl (SLICES=4, ROUNDS=2) against a schedule model
// derived from cycle offsets within a run.
module tb_permute_seq_ctrl;

  localparam int S     = 4;
  localparam int R     = 2;
  localparam int SW    = 2;
  localparam int RW    = 1;
  localparam int W     = SW + RW;
  localparam int PER   = 3 * S + 1;
  localparam int TOTAL = 1 + R * PER;
`ifdef PERMUTE_RD_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  localparam int PH_IDLE  = 0;
  localparam int PH_INIT  = 1;
  localparam int PH_LOAD  = 2;
  localparam int PH_CALC  = 3;
  localparam int PH_STORE = 4;
  localparam int PH_RND   = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          rd_valid;
  logic          rd_en, ld, sel, wr_en, slice_ready, round_done, done;
  logic [SW-1:0] addr;
  logic [RW-1:0] round;
  logic [2:0]    state_dbg;

  int n_checks = 0;
  int n_errs   = 0;

  permute_seq_ctrl #(.SLICES(S), .ROUNDS(R)) dut (
    .clk(clk), .rst(rst), .start(start), .rd_valid(rd_valid),
    .rd_en(rd_en), .ld(ld), .sel(sel), .wr_en(wr_en),
    .addr(addr), .round(round), .slice_ready(slice_ready),
    .round_done(round_done), .done(done), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Schedule model: a run is INIT followed by R rounds of (S slices x LOAD/CALC/STORE) + RND_END.
  function automatic int phase_of(input bit run, input int k);
    int p;
    if (!run) return PH_IDLE;
    if (k == 0) return PH_INIT;
    p = (k - 1) % PER;
    if (p == 3 * S) return PH_RND;
    return PH_LOAD + (p % 3);
  endfunction

  function automatic int slice_of(input int k);
    return ((k - 1) % PER) / 3;
  endfunction

  function automatic int round_of(input int k);
    return (k - 1) / PER;
  endfunction

  bit m_run;
  int m_k;
  int m_idle_round;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run        <= 1'b0;
      m_k          <= 0;
      m_idle_round <= 0;
    end else if (!m_run) begin
      if (start) begin
        m_run <= 1'b1;
        m_k   <= 0;
      end
    end else if (STALL && phase_of(1'b1, m_k) == PH_LOAD && !rd_valid) begin
      m_k <= m_k;
    end else if (m_k == TOTAL - 1) begin
      m_run        <= 1'b0;
      m_idle_round <= R - 1;
    end else begin
      m_k <= m_k + 1;
    end
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    int ph, e_addr, e_round, e_ld;
    ph      = phase_of(m_run, m_k);
    e_addr  = (ph == PH_LOAD || ph == PH_CALC || ph == PH_STORE) ? slice_of(m_k) : 0;
    e_round = (ph == PH_IDLE || ph == PH_INIT) ? m_idle_round : round_of(m_k);
    e_ld    = (ph == PH_LOAD) ? (STALL ? int'(rd_valid) : 1) : int'(ph == PH_CALC);
    check("done",        32'(done),        32'(ph == PH_IDLE));
    check("rd_en",       32'(rd_en),       32'(ph == PH_LOAD));
    check("ld",          32'(ld),          32'(e_ld));
    check("sel",         32'(sel),         32'(ph == PH_CALC));
    check("wr_en",       32'(wr_en),       32'(ph == PH_STORE));
    check("slice_ready", 32'(slice_ready), 32'(ph == PH_STORE));
    check("round_done",  32'(round_done),  32'(ph == PH_RND));
    check("addr",        32'(addr),        32'(e_addr));
    check("round",       32'(round),       32'(e_round));
  end

  // Monitor counters and write-back scoreboard.
  int low_cnt = 0;
  int wr_cnt  = 0;
  int rnd_cnt = 0;
  bit sb_en   = 1'b0;
  logic [W-1:0] exp_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (!done) low_cnt++;
      if (wr_en) wr_cnt++;
      if (round_done) rnd_cnt++;
      if (wr_en && sb_en) begin
        if (exp_q.size() == 0) check("sb_extra_write", 32'({round, addr}), 32'hffff_ffff);
        else check("sb_write_idx", 32'({round, addr}), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic clear_counts();
    low_cnt = 0;
    wr_cnt  = 0;
    rnd_cnt = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  // Waits for done to fall (if not already low) and then rise; returns at a negedge.
  task automatic wait_done(input string name);
    int i;
    i = 0;
    while (done && i < 20) begin @(negedge clk); i++; end
    while (!done && i < 400) begin @(negedge clk); i++; end
    if (!done) check({name, "_timeout"}, 32'(done), 32'd1);
  endtask

  initial begin
    start    = 1'b0;
    rd_valid = 1'b1;
    rst      = 1'b0;
    #1 rst   = 1'b1;
    #2;
    check("reset_done",  32'(done),  32'd1);
    check("reset_addr",  32'(addr),  32'd0);
    check("reset_round", 32'(round), 32'd0);
    check("reset_wr_en", 32'(wr_en), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Single run with write-back index scoreboard.
    clear_counts();
    for (int r = 0; r < R; r++)
      for (int s = 0; s < S; s++) exp_q.push_back(W'({r[RW-1:0], s[SW-1:0]}));
    sb_en = 1'b1;
    pulse_start();
    wait_done("run_a");
    sb_en = 1'b0;
    check("run_a_low_cycles", 32'(low_cnt), 32'd27);
    check("run_a_writes",     32'(wr_cnt),  32'd8);
    check("run_a_round_done", 32'(rnd_cnt), 32'd2);
    check("run_a_sb_empty",   32'(exp_q.size()), 32'd0);
    check("run_a_final_round", 32'(round), 32'(R - 1));

    // Start pulses while busy are ignored.
    @(posedge clk); #2 clear_counts();
    pulse_start();
    repeat (5) @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    repeat (9) @(posedge clk);
    #2 start = 1'b1;
    repeat (2) @(posedge clk);
    #2 start = 1'b0;
    wait_done("run_b");
    check("run_b_low_cycles", 32'(low_cnt), 32'd27);

    // Asynchronous reset in CALC of round 1 slice 2.
    pulse_start();
    for (int i = 0; i < 100 && !(m_run && m_k == 1 + PER + 2 * 3 + 1); i++) @(negedge clk);
    check("rst_target_sel", 32'(sel), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_done",  32'(done),  32'd1);
    check("async_ld",    32'(ld),    32'd0);
    check("async_sel",   32'(sel),   32'd0);
    check("async_wr_en", 32'(wr_en), 32'd0);
    check("async_addr",  32'(addr),  32'd0);
    check("async_round", 32'(round), 32'd0);
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b0;
    clear_counts();
    pulse_start();
    wait_done("run_c");
    check("run_c_low_cycles", 32'(low_cnt), 32'd27);
    check("run_c_writes",     32'(wr_cnt),  32'd8);

`ifdef PERMUTE_RD_STALL_EN
    // rd_valid held low for the first three LOAD cycles.
    @(posedge clk); #2 clear_counts();
    pulse_start();
    @(posedge clk); #2 rd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rd_valid = 1'b1;
    wait_done("run_stall");
    check("run_stall_low_cycles", 32'(low_cnt), 32'd30);
`endif

    // start held high: back-to-back runs with one idle cycle between.
    @(posedge clk); #2 clear_counts();
    start = 1'b1;
    wait_done("run_e1");
    check("run_e1_low_cycles", 32'(low_cnt), 32'd27);
    low_cnt = 0;
    @(negedge clk);
    check("start_held_gap", 32'(done), 32'd0);
    wait_done("run_e2");
    start = 1'b0;
    check("run_e2_low_cycles", 32'(low_cnt), 32'd27);

    // Randomized start / rd_valid traffic against the model.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #2;
      start    = ($urandom_range(0, 9) == 0);
      rd_valid = STALL ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
    end
    #0 start = 1'b0;
    rd_valid = 1'b1;
    wait_done("random_drain");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/permute_seq_ctrl.md
PERMUTE_SEQ_CTRL -- requirements
Module: permute_seq_ctrl

Interface
REQ-001 SHALL provide parameter SLICES, default 64, meaning slices processed per round (>=2).
REQ-002 SHALL provide parameter ROUNDS, default 24, meaning rounds per permutation (>=1).
REQ-003 SHALL derive SW = max(1, clog2(SLICES)) and RW = max(1, clog2(ROUNDS)) as internal widths.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port start, input, 1, request new permutation; sampled only in IDLE.
REQ-007 SHALL have port rd_valid, input, 1, read data valid from state memory (used only per REQ-027).
REQ-008 SHALL have port rd_en, output, 1, state memory read request.
REQ-009 SHALL have port ld, output, 1, datapath register load enable.
REQ-010 SHALL have port sel, output, 1, datapath mux select: 0 = memory data, 1 = round-function result.
REQ-011 SHALL have port wr_en, output, 1, state memory write-back strobe.
REQ-012 SHALL have port addr, output, SW, current slice index.
REQ-013 SHALL have port round, output, RW, current round index.
REQ-014 SHALL have port slice_ready, output, 1, one-cycle pulse per completed slice.
REQ-015 SHALL have port round_done, output, 1, one-cycle pulse per completed round.
REQ-016 SHALL have port done, output, 1, high whenever idle (permutation complete or never started).

Function
REQ-017 SHALL implement FSM states IDLE, INIT, LOAD, CALC, STORE, RND_END.
REQ-018 Transitions SHALL be: IDLE->INIT on start; INIT->LOAD; LOAD->CALC; CALC->STORE; STORE->LOAD if addr<SLICES-1 else RND_END; RND_END->LOAD if round<ROUNDS-1 else IDLE.
REQ-019 Outputs SHALL be Moore-decoded; unlisted outputs 0: IDLE done=1; LOAD rd_en=1, ld=1, sel=0; CALC ld=1, sel=1; STORE wr_en=1, slice_ready=1; RND_END round_done=1.
REQ-020 INIT SHALL clear addr and round to 0.
REQ-021 addr SHALL increment on STORE->LOAD and clear to 0 on STORE->RND_END; no wrap beyond SLICES-1.
REQ-022 round SHALL increment on RND_END->LOAD and hold its final value (ROUNDS-1) in IDLE.
REQ-023 Latency, start sampled to done high: 1 + ROUNDS*(3*SLICES+1) cycles (no stalls).
REQ-024 start while not IDLE SHALL be ignored; start held high in IDLE on completion SHALL begin a new permutation immediately (done high exactly one cycle).
REQ-025 addr and round SHALL be stable for the full LOAD/CALC/STORE triple of a slice.

Reset
REQ-026 rst high SHALL force IDLE, addr=0, round=0, done=1, all other outputs 0, immediately and independent of clk, including mid-permutation; no write-back SHALL occur after assertion.

Configuration
REQ-027 Macro PERMUTE_RD_STALL_EN: defined -> LOAD holds with rd_en=1 and ld=rd_valid, advancing to CALC only on rd_valid=1; undefined -> rd_valid ignored, LOAD lasts exactly one cycle, ld=1.

Verification
REQ-028 SLICES=4, ROUNDS=2, one start pulse -> done low for exactly 27 cycles, 8 wr_en pulses, 2 round_done pulses.
REQ-029 Same config -> addr sequence 0,1,2,3 per round; round 0 then 1; wr_en never with sel=1.
REQ-030 start pulsed mid-round -> ignored; total cycles remain 27.
REQ-031 rst asserted in CALC of round 1 slice 2 -> outputs at reset values before next clk edge; later start -> full 27-cycle run.
REQ-032 PERMUTE_RD_STALL_EN defined, rd_valid low 3 cycles in first LOAD -> FSM held in LOAD, ld=0 for those cycles, done low for 30 cycles.
REQ-033 start held high continuously -> done high one cycle between back-to-back 27-cycle runs.
